// File: rtl/mmio_responder_pkg.sv
// Shared MMIO register map: offsets relative to the region base and status-word bit positions.
// Reused by the core's load path and by software headers.
package mmio_responder_pkg;

  typedef enum logic [7:0] {
    MMIO_STATUS = 8'h00,
    MMIO_RX     = 8'h04,
    MMIO_TX     = 8'h08,
    MMIO_CYC    = 8'h10,
    MMIO_INST   = 8'h14,
    MMIO_CRST   = 8'h18
  } mmio_off_e;

  localparam int STAT_TX_NFULL = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_OVF      = 2;

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Single-clock FIFO with a combinational head (dout) and occupancy tracked by a count register.
// A push while full is accepted only when a pop happens in the same cycle.
module mmio_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder beside the DMEM/IMEM decode: UART TX FIFO, RX holding register,
// cycle/instruction counters and a registered read port with BRAM-like 1-cycle latency.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wbe_i,
  input  logic        wen_i,
  input  logic        ren_i,
  output logic [31:0] rdata_o,
  input  logic        inst_ret_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  logic        hit, rd_hit, wr_hit;
  logic [7:0]  off;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        ovf_set, stat_rd, rx_rd, cnt_rst;
  logic [31:0] status_w;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;
  logic        ovf_q, ovf_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;

  logic unused_bits;
  assign unused_bits = ^{addr_i[29:8], wdata_i[31:8], wbe_i[3:1]};

  assign hit    = (addr_i[31:30] == MMIO_BASE[31:30]);
  assign off    = addr_i[7:0];
  assign rd_hit = ren_i & hit;
  assign wr_hit = wen_i & hit;

  assign stat_rd = rd_hit & (off == MMIO_STATUS);
  assign rx_rd   = rd_hit & (off == MMIO_RX);
  assign cnt_rst = wr_hit & (off == MMIO_CRST);
  assign tx_push = wr_hit & (off == MMIO_TX) & wbe_i[0];
  assign tx_pop  = tx_valid_o & tx_ready_i;
  // A refused push is one that finds the FIFO full with no simultaneous drain.
  assign ovf_set = tx_push & tx_full & ~tx_pop;

  mmio_responder_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .din_i   (wdata_i[7:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full_q;
  assign rdata_o    = rdata_q;

  always_comb begin
    status_w                = '0;
    status_w[STAT_TX_NFULL] = ~tx_full;
    status_w[STAT_RX_FULL]  = rx_full_q;
    status_w[STAT_OVF]      = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_hit) begin
      case (off)
        MMIO_STATUS: rdata_d = status_w;
        MMIO_RX:     rdata_d = rx_full_q ? {24'b0, rx_byte_q} : 32'b0;
        MMIO_CYC:    rdata_d = cyc_q;
        MMIO_INST:   rdata_d = inst_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    cyc_d     = cyc_q + 32'd1;
    inst_d    = inst_q + {31'b0, inst_ret_i};
    if (ovf_set)      ovf_d = 1'b1;
    else if (stat_rd) ovf_d = 1'b0;
    // Capture only when empty, so a same-cycle pop-and-arrival waits a cycle on rx_ready.
    if (rx_rd && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (rx_valid_i && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data_i;
    end
    if (cnt_rst) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      cyc_q     <= '0;
      inst_q    <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed vector table, hand-written FIFO/reset sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_mmio_responder;

  localparam int          DEPTH = 8;
  localparam logic [31:0] B     = 32'h8000_0000;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wbe;
  logic        wen, ren, inst_ret;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int checks = 0;
  int errors = 0;

  mmio_responder #(.TX_DEPTH(DEPTH), .MMIO_BASE(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .wbe_i      (wbe),
    .wen_i      (wen),
    .ren_i      (ren),
    .rdata_o    (rdata),
    .inst_ret_i (inst_ret),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0] m_cyc, m_inst, m_rdata;
  bit        m_rxfull, m_ovf;
  bit [7:0]  m_rxbyte;
  bit [7:0]  m_q[$];

  task automatic model_reset();
    m_cyc = 0; m_inst = 0; m_rdata = 0;
    m_rxfull = 0; m_ovf = 0; m_rxbyte = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit        h, pop, push, ovfset;
    bit [7:0]  o;
    bit [31:0] nrd;
    h = (addr[31:30] == 2'b10);
    o = addr[7:0];
    nrd = 0;
    if (ren && h) begin
      case (o)
        8'h00: nrd = {29'b0, m_ovf, m_rxfull, (m_q.size() < DEPTH)};
        8'h04: nrd = m_rxfull ? {24'b0, m_rxbyte} : 32'b0;
        8'h10: nrd = m_cyc;
        8'h14: nrd = m_inst;
        default: nrd = 0;
      endcase
    end
    pop    = (m_q.size() > 0) && tx_ready;
    push   = wen && h && (o == 8'h08) && wbe[0];
    ovfset = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !ovfset) m_q.push_back(wdata[7:0]);
    if (ovfset) m_ovf = 1;
    else if (ren && h && o == 8'h00) m_ovf = 0;
    if (ren && h && o == 8'h04 && m_rxfull) m_rxfull = 0;
    else if (rx_valid && !m_rxfull) begin
      m_rxfull = 1;
      m_rxbyte = rx_data;
    end
    if (wen && h && o == 8'h18) begin
      m_cyc = 0;
      m_inst = 0;
    end else begin
      m_cyc  = m_cyc + 1;
      m_inst = m_inst + {31'b0, inst_ret};
    end
    m_rdata = nrd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sees at this edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("m_rdata", rdata, m_rdata);
    chk("m_tx_valid", {31'b0, tx_valid}, {31'b0, (m_q.size() > 0)});
    chk("m_rx_ready", {31'b0, rx_ready}, {31'b0, !m_rxfull});
    if (m_q.size() > 0) chk("m_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
  endtask

  task automatic idle();
    ren = 0; wen = 0; addr = 0; wdata = 0; wbe = 0;
    inst_ret = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic        inst, txr, rxv;
    logic [7:0]  rxd;
    logic [31:0] e_rdata;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_rxr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic i, input logic txr, input logic rxv, input logic [7:0] rxd,
                     input logic [31:0] er, input logic etv, input logic [7:0] etd, input logic err);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.wdata = d;
    v.inst = i; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.e_rdata = er; v.e_txv = etv; v.e_txd = etd; v.e_rxr = err;
    tbl.push_back(v);
  endtask

  bit [7:0] drain_exp[$];

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();

    //   r  w  addr          wdata  i  txr rxv rxd     rdata        txv txd    rxr
    add(0, 0, B,            0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(0, 0, B,            0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, B,            0,     0, 0,  0,  8'h00,  32'h1,       0,  8'h00, 1);
    add(1, 0, B + 32'h10,   0,     0, 0,  0,  8'h00,  32'h3,       0,  8'h00, 1);
    add(0, 1, B + 32'h08,   'h41,  0, 0,  0,  8'h00,  32'h0,       1,  8'h41, 1);
    add(0, 1, B + 32'h08,   'h42,  0, 0,  0,  8'h00,  32'h0,       1,  8'h41, 1);
    add(0, 0, B,            0,     0, 1,  0,  8'h00,  32'h0,       1,  8'h42, 1);
    add(0, 0, B,            0,     0, 1,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(0, 0, B,            0,     0, 0,  1,  8'h5A,  32'h0,       0,  8'h00, 0);
    add(1, 0, B,            0,     0, 0,  0,  8'h00,  32'h3,       0,  8'h00, 0);
    add(1, 0, B + 32'h04,   0,     0, 0,  0,  8'h00,  32'h5A,      0,  8'h00, 1);
    add(1, 0, B + 32'h04,   0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, B + 32'h20,   0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, 32'h0000_0010,0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, 32'hC000_0000,0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(0, 1, 32'h4000_0008,'h77,  0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(0, 1, B + 32'h18,   0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, B + 32'h10,   0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, B + 32'h14,   0,     0, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    for (int k = 0; k < 5; k++)
      add(0, 0, B,          0,     1, 0,  0,  8'h00,  32'h0,       0,  8'h00, 1);
    add(1, 0, B + 32'h14,   0,     0, 0,  0,  8'h00,  32'h5,       0,  8'h00, 1);

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int v = 0; v < tbl.size(); v++) begin
      ren = tbl[v].ren; wen = tbl[v].wen; addr = tbl[v].addr; wdata = tbl[v].wdata;
      wbe = tbl[v].wen ? 4'h1 : 4'h0;
      inst_ret = tbl[v].inst; tx_ready = tbl[v].txr;
      rx_valid = tbl[v].rxv; rx_data = tbl[v].rxd;
      cyc();
      $display("vec %0d addr=%h rdata=%h tx_valid=%0d tx_data=%h rx_ready=%0d",
               v, tbl[v].addr, rdata, tx_valid, tx_data, rx_ready);
      chk("vec_rdata", rdata, tbl[v].e_rdata);
      chk("vec_tx_valid", {31'b0, tx_valid}, {31'b0, tbl[v].e_txv});
      chk("vec_rx_ready", {31'b0, rx_ready}, {31'b0, tbl[v].e_rxr});
      if (tbl[v].e_txv) chk("vec_tx_data", {24'b0, tx_data}, {24'b0, tbl[v].e_txd});
    end

    // Fill, overflow, status clear, push-while-full-with-pop.
    idle();
    for (int k = 0; k < DEPTH + 1; k++) begin
      wen = 1; wbe = 4'h1; addr = B + 32'h08; wdata = 32'h30 + k;
      cyc();
    end
    idle();
    ren = 1; addr = B;
    cyc();
    chk("ovf_status", rdata, 32'h4);
    cyc();
    chk("ovf_cleared", rdata, 32'h0);
    idle();
    wen = 1; wbe = 4'h1; addr = B + 32'h08; wdata = 32'h55; tx_ready = 1;
    cyc();
    idle();
    tx_ready = 1;
    drain_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h55};
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_order", {24'b0, tx_data}, {24'b0, drain_exp[k]});
      cyc();
    end
    chk("drain_empty", {31'b0, tx_valid}, 32'h0);

    // Randomized traffic against the model.
    begin
      logic [7:0] offs [8];
      offs = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C};
      for (int n = 0; n < 3000; n++) begin
        logic [1:0] reg_top;
        ren = 1'($urandom_range(0, 1));
        wen = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) != 0) reg_top = 2'b10;
        else reg_top = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        addr = {reg_top, 22'($urandom), offs[$urandom_range(0, 7)]};
        if (addr[7:0] == 8'h18 && $urandom_range(0, 7) != 0) wen = 0;
        wdata = $urandom;
        wbe = 4'($urandom);
        inst_ret = 1'($urandom_range(0, 1));
        tx_ready = ($urandom_range(0, 3) == 0);
        rx_valid = 1'($urandom_range(0, 1));
        rx_data = 8'($urandom);
        cyc();
      end
    end

    // Reset asserted mid-transfer with FIFO half full and RX byte pending.
    idle();
    tx_ready = 1;
    repeat (DEPTH + 2) cyc();
    idle();
    rx_valid = 1; rx_data = 8'hA5;
    for (int k = 0; k < DEPTH / 2; k++) begin
      wen = 1; wbe = 4'h1; addr = B + 32'h08; wdata = 32'h60 + k;
      cyc();
    end
    idle();
    chk("pre_rst_tx_valid", {31'b0, tx_valid}, 32'h1);
    chk("pre_rst_rx_ready", {31'b0, rx_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("async_rx_ready", {31'b0, rx_ready}, 32'h1);
    chk("async_rdata", rdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tx_ready = 1;
    repeat (3) cyc();
    ren = 1; addr = B + 32'h04;
    cyc();
    chk("post_rst_rx", rdata, 32'h0);
    addr = B;
    cyc();
    chk("post_rst_status", rdata, 32'h1);
    idle();
    cyc();
    chk("post_rst_tx_valid", {31'b0, tx_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
